// File: rtl/if_fetch.sv
// Instruction fetch stage: credit-limited requests to instruction memory, in-order
// response tracking with redirect squashing, and a registered 2-entry {pc, inst} output FIFO.
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch_flag,
    input  logic [31:0] branch_target_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    input  logic        id_ready
);
    logic [31:0] pc_q, pc_d;
    logic [1:0]  out_cnt_q, out_cnt_d;
    logic [1:0]  disc_q, disc_d;
    logic        pend_head_q, pend_head_d;
    logic [1:0]  fifo_cnt_q, fifo_cnt_d;
    logic        fifo_head_q, fifo_head_d;
    logic [31:0] pend_addr_q [2];
    logic [31:0] fifo_pc_q   [2];
    logic [31:0] fifo_inst_q [2];

    logic grant, rsp, rsp_keep, fifo_pop;
    logic pend_wr_idx, fifo_wr_idx;

    // Each request reserves a FIFO slot up front, so a response can never be refused.
    assign imem_req    = !rst && !branch_flag &&
                         (({1'b0, out_cnt_q} + {1'b0, fifo_cnt_q}) < 3'd2);
    assign imem_addr   = pc_q;
    assign grant       = imem_req && imem_gnt;
    assign rsp         = imem_rvalid && (out_cnt_q != 2'd0);
    assign rsp_keep    = rsp && !branch_flag && (disc_q == 2'd0);
    assign fifo_pop    = if_valid && id_ready && !branch_flag;
    assign pend_wr_idx = pend_head_q ^ out_cnt_q[0];
    assign fifo_wr_idx = fifo_head_q ^ fifo_cnt_q[0];

    assign if_valid = (fifo_cnt_q != 2'd0);
    assign if_pc    = if_valid ? fifo_pc_q[fifo_head_q]   : 32'h0;
    assign if_inst  = if_valid ? fifo_inst_q[fifo_head_q] : 32'h0;

    always_comb begin
        // NOTE: every next-state value is defaulted first so no branch can infer a latch.
        pc_d        = pc_q;
        disc_d      = disc_q;
        pend_head_d = pend_head_q;
        fifo_head_d = fifo_head_q;
        fifo_cnt_d  = fifo_cnt_q;
        out_cnt_d   = out_cnt_q + {1'b0, grant} - {1'b0, rsp};
        if (grant) pc_d = pc_q + 32'd4;
        if (rsp)   pend_head_d = ~pend_head_q;
        if (branch_flag) begin
            // Everything still in flight after this edge belongs to the old path.
            pc_d       = branch_target_addr & 32'hFFFF_FFFC;
            fifo_cnt_d = 2'd0;
            disc_d     = out_cnt_q - {1'b0, rsp};
        end else begin
            if (rsp && (disc_q != 2'd0)) disc_d = disc_q - 2'd1;
            fifo_cnt_d = fifo_cnt_q + {1'b0, rsp_keep} - {1'b0, fifo_pop};
            if (fifo_pop) fifo_head_d = ~fifo_head_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            out_cnt_q   <= 2'd0;
            disc_q      <= 2'd0;
            pend_head_q <= 1'b0;
            fifo_cnt_q  <= 2'd0;
            fifo_head_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            out_cnt_q   <= out_cnt_d;
            disc_q      <= disc_d;
            pend_head_q <= pend_head_d;
            fifo_cnt_q  <= fifo_cnt_d;
            fifo_head_q <= fifo_head_d;
        end
    end

    // NOTE: storage arrays are not reset; counters qualify every read and outputs are gated.
    always_ff @(posedge clk) begin
        if (grant) pend_addr_q[pend_wr_idx] <= pc_q;
        if (rsp_keep) begin
            fifo_pc_q[fifo_wr_idx]   <= pend_addr_q[pend_head_q];
            fifo_inst_q[fifo_wr_idx] <= imem_rdata;
        end
    end
endmodule
